sector_mem_arb: RTL and testbench

SECTOR_MEM_ARB -- requirements
Module: sector_mem_arb

---
 rtl/sector_mem_arb_pkg.sv | 30 +++
 rtl/sector_mem_arb_rr_pick3.sv | 41 ++++
 rtl/sector_mem_arb.sv | 145 ++++++++++++++
 tb/tb_sector_mem_arb.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sector_mem_arb_pkg.sv
// Shared sift sector definitions used by the sector memory arbiter and the
// sector controller: requester indices, burst/address limits, FSM encoding
// and a one-hot to index helper.
package sector_mem_arb_pkg;

  localparam int ING = 0;  // AXIS ingress writer
  localparam int EGR = 1;  // AXIS egress reader
  localparam int CTL = 2;  // sector controller microprogram

  localparam logic [2:0] OH_ING = 3'b001;
  localparam logic [2:0] OH_EGR = 3'b010;
  localparam logic [2:0] OH_CTL = 3'b100;

  // One IFP record (DATA_SIZE words) per grant.
  localparam int ARB_MAX_BURST = 38;
  // Highest legal word address of the sector memory.
  localparam int ARB_MAX_ADDR  = 569;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
    if (oh[EGR]) return 2'(EGR);
    if (oh[CTL]) return 2'(CTL);
    return 2'(ING);
  endfunction

endpackage

// File: rtl/sector_mem_arb_rr_pick3.sv
// rr_pick3: combinational 3-way round-robin picker.
// Ports:
//   req  - request vector
//   mask - eligibility mask (requester considered only if mask bit set)
//   last - index of the previous winner; search starts at (last+1) mod 3
//   gnt  - one-hot winner, zero when nothing eligible
module rr_pick3
  import sector_mem_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [2:0] mask,
  input  logic [1:0] last,
  output logic [2:0] gnt
);

  logic [2:0] eff;

  assign eff = req & mask;

  always_comb begin
    gnt = 3'b000;
    case (last)
      2'd0: begin
        if      (eff[EGR]) gnt = OH_EGR;
        else if (eff[CTL]) gnt = OH_CTL;
        else if (eff[ING]) gnt = OH_ING;
      end
      2'd1: begin
        if      (eff[CTL]) gnt = OH_CTL;
        else if (eff[ING]) gnt = OH_ING;
        else if (eff[EGR]) gnt = OH_EGR;
      end
      default: begin
        if      (eff[ING]) gnt = OH_ING;
        else if (eff[EGR]) gnt = OH_EGR;
        else if (eff[CTL]) gnt = OH_CTL;
      end
    endcase
  end

endmodule

// File: rtl/sector_mem_arb.sv
// sector_mem_arb: burst arbiter granting one of three requesters (ingress
// writer, egress reader, sector controller) access to the single-port sector
// memory. Grants are registered, beats pass through combinationally, reads
// return one cycle after the accepted beat.
// Ports:
//   axis_clk_i, axis_rstn_i      - clock, asynchronous active-low reset
//   req_i/we_i/last_i            - per-requester beat request, write, last beat
//   addr_i/wdata_i               - packed per-requester address / write data
//   ctrl_lock_i                  - run phase: only the controller may be granted
//   gnt_o                        - one-hot-or-zero registered grant
//   rvalid_o/rdata_o             - per-requester read valid, shared read data
//   mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_rdata_i - memory port
//   err_o/err_clr_i              - sticky out-of-range flag and its clear
module sector_mem_arb
  import sector_mem_arb_pkg::*;
#(
  parameter int                 ADDR_W    = 16,
  parameter int                 DATA_W    = 32,
  parameter int                 MAX_BURST = ARB_MAX_BURST,
  parameter logic [ADDR_W-1:0]  MAX_ADDR  = ADDR_W'(ARB_MAX_ADDR)
) (
  input  logic                  axis_clk_i,
  input  logic                  axis_rstn_i,
  input  logic [2:0]            req_i,
  input  logic [2:0]            we_i,
  input  logic [2:0]            last_i,
  input  logic [3*ADDR_W-1:0]   addr_i,
  input  logic [3*DATA_W-1:0]   wdata_i,
  input  logic                  ctrl_lock_i,
  output logic [2:0]            gnt_o,
  output logic [2:0]            rvalid_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  output logic                  err_o,
  input  logic                  err_clr_i
);

  localparam logic [5:0] BEAT_LAST = 6'(MAX_BURST - 1);

  arb_state_e        state_q, state_d;
  logic [2:0]        gnt_d;
  logic [1:0]        last_q, last_d;
  logic [5:0]        beat_q, beat_d;
  logic [2:0]        elig_mask;
  logic [2:0]        pick;
  logic [1:0]        sel;
  logic [ADDR_W-1:0] sel_addr;
  logic              granted_req;
  logic              lock_abort;
  logic              accept;
  logic              in_range;
  logic              err_set;
  logic [2:0]        rd_vld_p1;
  logic [DATA_W-1:0] rdata_q;

  assign elig_mask = ctrl_lock_i ? OH_CTL : 3'b111;

  rr_pick3 u_pick (
    .req  (req_i),
    .mask (elig_mask),
    .last (last_q),
    .gnt  (pick)
  );

  // ---- stage p0: beat acceptance, combinational to the memory port ----
  assign sel         = onehot_to_idx(gnt_o);
  assign sel_addr    = addr_i[int'(sel)*ADDR_W +: ADDR_W];
  assign granted_req = |(gnt_o & req_i);
  // Lock can only be high during an ingress/egress grant on the cycle it rises.
  assign lock_abort  = ctrl_lock_i & (gnt_o[ING] | gnt_o[EGR]);
  assign accept      = granted_req & ~lock_abort;
  assign in_range    = (sel_addr <= MAX_ADDR);
  assign err_set     = accept & ~in_range;

  assign mem_en_o    = accept & in_range;
  assign mem_we_o    = accept & in_range & we_i[sel];
  assign mem_addr_o  = sel_addr;
  assign mem_wdata_o = wdata_i[int'(sel)*DATA_W +: DATA_W];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_o;
    last_d  = last_q;
    beat_d  = beat_q;
    case (state_q)
      ARB_IDLE: begin
        if (|pick) begin
          state_d = ARB_BURST;
          gnt_d   = pick;
          beat_d  = 6'd0;
        end
      end
      ARB_BURST: begin
        if (accept) begin
          beat_d = (beat_q == BEAT_LAST) ? 6'd0 : beat_q + 6'd1;
        end
        if (lock_abort || !granted_req ||
            (accept && (last_i[sel] || beat_q == BEAT_LAST))) begin
          state_d = ARB_IDLE;
          gnt_d   = 3'b000;
          last_d  = sel;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = 3'b000;
      end
    endcase
  end

  // ---- stage p1: registered grant, read return, error flag ----
  always_ff @(posedge axis_clk_i or negedge axis_rstn_i) begin
    if (!axis_rstn_i) begin
      state_q   <= ARB_IDLE;
      gnt_o     <= 3'b000;
      last_q    <= 2'(CTL);
      beat_q    <= 6'd0;
      rd_vld_p1 <= 3'b000;
      err_o     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      gnt_o     <= gnt_d;
      last_q    <= last_d;
      beat_q    <= beat_d;
      rd_vld_p1 <= (mem_en_o & ~mem_we_o) ? gnt_o : 3'b000;
      if (err_set) begin
        err_o <= 1'b1;
      end else if (err_clr_i) begin
        err_o <= 1'b0;
      end
      if (|rd_vld_p1) begin
        rdata_q <= mem_rdata_i;
      end
    end
  end

  assign rvalid_o = rd_vld_p1;
  assign rdata_o  = (|rd_vld_p1) ? mem_rdata_i : rdata_q;

endmodule

// File: tb/tb_sector_mem_arb.sv
module tb_sector_mem_arb;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int MAXB   = 38;
  localparam int MAXA   = 569;

  logic                clk = 1'b0;
  logic                rstn;
  logic [2:0]          req, we, last;
  logic [3*ADDR_W-1:0] addr;
  logic [3*DATA_W-1:0] wdata;
  logic                lock, clr;
  logic [2:0]          gnt, rvalid;
  logic [DATA_W-1:0]   rdata, mem_wdata, mem_rdata;
  logic                mem_en, mem_we, err;
  logic [ADDR_W-1:0]   mem_addr;
  logic                ram_init;
  logic [DATA_W-1:0]   ram [0:1023];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sector_mem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .axis_clk_i  (clk),
    .axis_rstn_i (rstn),
    .req_i       (req),
    .we_i        (we),
    .last_i      (last),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .ctrl_lock_i (lock),
    .gnt_o       (gnt),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .mem_en_o    (mem_en),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .err_o       (err),
    .err_clr_i   (clr)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'h5A00_0000 ^ (i * 32'h0001_9E37);
  endfunction

  // Synchronous single-port memory: read data one cycle after the enable.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_word(i);
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[9:0]];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req = 3'b000; we = 3'b000; last = 3'b000; lock = 1'b0; clr = 1'b0;
    addr = '0; wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  typedef struct {
    logic [2:0]  req, we, last;
    logic        lock, clr;
    logic [15:0] a;
    logic [2:0]  e_gnt;
    logic        e_en, e_we, e_err;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] r, input logic [2:0] w, input logic [2:0] l,
                              input logic lk, input logic c, input logic [15:0] a,
                              input logic [2:0] g, input logic en, input logic wen,
                              input logic er);
    vec_t v;
    v.req = r; v.we = w; v.last = l; v.lock = lk; v.clr = c; v.a = a;
    v.e_gnt = g; v.e_en = en; v.e_we = wen; v.e_err = er;
    return v;
  endfunction

  vec_t tbl [17];

  // Reference model state for the random phase.
  int               m_owner, m_lastw, m_beats;
  logic             m_err, m_lock_prev;
  logic [2:0]       m_pend;
  logic [31:0]      m_pend_data, m_hold;
  logic [31:0]      shadow [0:1023];

  initial begin
    rstn = 1'b0;
    ram_init = 1'b0;
    idle_inputs();

    // Single-beat round robin, out-of-range access, error clear and set-wins.
    tbl[0]  = mk(3'b111, 3'b111, 3'b111, 0, 0, 16'd3,   3'b000, 0, 0, 0);
    tbl[1]  = mk(3'b111, 3'b111, 3'b111, 0, 0, 16'd3,   3'b001, 1, 1, 0);
    tbl[2]  = mk(3'b111, 3'b111, 3'b111, 0, 0, 16'd3,   3'b000, 0, 0, 0);
    tbl[3]  = mk(3'b111, 3'b111, 3'b111, 0, 0, 16'd3,   3'b010, 1, 1, 0);
    tbl[4]  = mk(3'b111, 3'b111, 3'b111, 0, 0, 16'd3,   3'b000, 0, 0, 0);
    tbl[5]  = mk(3'b111, 3'b111, 3'b111, 0, 0, 16'd3,   3'b100, 1, 1, 0);
    tbl[6]  = mk(3'b111, 3'b111, 3'b111, 0, 0, 16'd3,   3'b000, 0, 0, 0);
    tbl[7]  = mk(3'b111, 3'b111, 3'b111, 0, 0, 16'd3,   3'b001, 1, 1, 0);
    tbl[8]  = mk(3'b010, 3'b010, 3'b010, 0, 0, 16'd600, 3'b000, 0, 0, 0);
    tbl[9]  = mk(3'b010, 3'b010, 3'b010, 0, 0, 16'd600, 3'b010, 0, 0, 0);
    tbl[10] = mk(3'b000, 3'b000, 3'b000, 0, 0, 16'd600, 3'b000, 0, 0, 1);
    tbl[11] = mk(3'b000, 3'b000, 3'b000, 0, 1, 16'd600, 3'b000, 0, 0, 1);
    tbl[12] = mk(3'b100, 3'b100, 3'b100, 0, 0, 16'd600, 3'b000, 0, 0, 0);
    tbl[13] = mk(3'b100, 3'b100, 3'b100, 0, 1, 16'd600, 3'b100, 0, 0, 0);
    tbl[14] = mk(3'b011, 3'b000, 3'b000, 1, 0, 16'd3,   3'b000, 0, 0, 1);
    tbl[15] = mk(3'b011, 3'b000, 3'b000, 1, 0, 16'd3,   3'b000, 0, 0, 1);
    tbl[16] = mk(3'b000, 3'b000, 3'b000, 0, 0, 16'd3,   3'b000, 0, 0, 1);

    // Reset state.
    do_reset();
    #1;
    check("rst_gnt",    gnt,    0);
    check("rst_rvalid", rvalid, 0);
    check("rst_err",    err,    0);
    check("rst_rdata",  rdata,  0);
    check("rst_mem_en", mem_en, 0);

    // Table-driven vectors.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      req = tbl[i].req; we = tbl[i].we; last = tbl[i].last;
      lock = tbl[i].lock; clr = tbl[i].clr;
      addr  = {3{tbl[i].a}};
      wdata = {32'hC0C0_0002, 32'hB0B0_0001, 32'hA0A0_0000};
      #1;
      check($sformatf("tbl%0d_gnt", i),    gnt,    tbl[i].e_gnt);
      check($sformatf("tbl%0d_mem_en", i), mem_en, tbl[i].e_en);
      check($sformatf("tbl%0d_mem_we", i), mem_we, tbl[i].e_we);
      check($sformatf("tbl%0d_err", i),    err,    tbl[i].e_err);
    end

    // Full-length ingress burst without last: ends after beat 38.
    do_reset();
    @(negedge clk);
    req = 3'b001; we = 3'b001;
    #1;
    check("burst_idle_gnt", gnt, 0);
    for (int b = 0; b < MAXB; b++) begin
      @(negedge clk);
      addr[15:0] = 16'(b); wdata[31:0] = 32'(b);
      #1;
      check($sformatf("burst_b%0d_gnt", b),  gnt,      3'b001);
      check($sformatf("burst_b%0d_en", b),   mem_en,   1);
      check($sformatf("burst_b%0d_addr", b), mem_addr, b);
    end
    @(negedge clk);
    #1;
    check("burst_end_gnt", gnt, 0);
    @(negedge clk);
    #1;
    check("burst_regrant_gnt", gnt, 3'b001);
    idle_inputs();

    // Write 0xDEADBEEF to addr 5 via ingress, read it back via egress.
    do_reset();
    @(negedge clk);
    req = 3'b001; we = 3'b001; last = 3'b001;
    addr = {3{16'd5}}; wdata = {32'd0, 32'd0, 32'hDEAD_BEEF};
    @(negedge clk);
    #1;
    check("wr5_mem_we", mem_we, 1);
    @(negedge clk);
    req = 3'b010; we = 3'b000; last = 3'b010;
    @(negedge clk);
    #1;
    check("rd5_gnt",    gnt,    3'b010);
    check("rd5_en_rd",  {mem_en, mem_we}, 2'b10);
    @(negedge clk);
    idle_inputs();
    #1;
    check("rd5_rvalid", rvalid, 3'b010);
    check("rd5_rdata",  rdata,  32'hDEAD_BEEF);
    @(negedge clk);
    #1;
    check("rd5_rvalid_drop", rvalid, 3'b000);
    check("rd5_rdata_hold",  rdata,  32'hDEAD_BEEF);

    // Lock rises mid ingress burst at beat 11.
    do_reset();
    @(negedge clk);
    req = 3'b001; we = 3'b001; addr = {3{16'd100}};
    for (int b = 0; b < 10; b++) begin
      @(negedge clk);
      #1;
      check($sformatf("lock_b%0d_en", b), mem_en, 1);
    end
    @(negedge clk);
    lock = 1'b1; req = 3'b101; we = 3'b101;
    #1;
    check("lock_rise_gnt", gnt,    3'b001);
    check("lock_rise_en",  mem_en, 0);
    @(negedge clk);
    #1;
    check("lock_idle_gnt", gnt, 0);
    @(negedge clk);
    #1;
    check("lock_ctl_gnt", gnt,    3'b100);
    check("lock_ctl_en",  mem_en, 1);
    idle_inputs();

    // Reset asserted while a read is in flight.
    do_reset();
    @(negedge clk);
    req = 3'b010; we = 3'b000; last = 3'b000; addr = {3{16'd7}};
    @(negedge clk);
    #1;
    check("rstrd_gnt", gnt,    3'b010);
    check("rstrd_en",  mem_en, 1);
    @(posedge clk);
    #2;
    check("rstrd_rvalid_pre", rvalid, 3'b010);
    rstn = 1'b0;
    #1;
    check("rstrd_gnt_async",    gnt,    0);
    check("rstrd_rvalid_async", rvalid, 0);
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("rstrd_post%0d_rvalid", c), rvalid, 0);
    end

    // Randomized traffic against the reference model.
    @(negedge clk);
    rstn = 1'b0;
    ram_init = 1'b1;
    @(negedge clk);
    ram_init = 1'b0;
    for (int i = 0; i < 1024; i++) shadow[i] = init_word(i);
    @(negedge clk);
    rstn = 1'b1;
    m_owner = -1; m_lastw = 2; m_beats = 0; m_err = 1'b0; m_lock_prev = 1'b0;
    m_pend = 3'b000; m_pend_data = '0; m_hold = '0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [2:0]  e_gnt;
      logic        abort, acc, inr, e_en, e_we;
      logic [15:0] oa;
      logic        fin;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        req[k]  = ($urandom_range(0, 3) != 0);
        we[k]   = $urandom_range(0, 1) == 1;
        last[k] = ($urandom_range(0, 7) == 0);
        addr[k*16 +: 16]  = 16'($urandom_range(0, 620));
        wdata[k*32 +: 32] = $urandom;
      end
      if ($urandom_range(0, 39) == 0) lock = ~lock;
      clr = ($urandom_range(0, 9) == 0);
      #1;

      e_gnt = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
      abort = (m_owner == 0 || m_owner == 1) && lock && !m_lock_prev;
      acc   = (m_owner >= 0) && req[m_owner] && !abort;
      oa    = (m_owner >= 0) ? addr[m_owner*16 +: 16] : 16'd0;
      inr   = (int'(oa) <= MAXA);
      e_en  = acc && inr;
      e_we  = e_en && we[m_owner];

      check("rnd_gnt",    gnt,    e_gnt);
      check("rnd_mem_en", mem_en, e_en);
      check("rnd_mem_we", mem_we, e_we);
      if (e_en) begin
        check("rnd_mem_addr", mem_addr, oa);
        if (e_we) check("rnd_mem_wdata", mem_wdata, wdata[m_owner*32 +: 32]);
      end
      check("rnd_rvalid", rvalid, m_pend);
      check("rnd_rdata",  rdata,  (m_pend != 0) ? m_pend_data : m_hold);
      check("rnd_err",    err,    m_err);

      // Advance the model by one clock.
      if (m_pend != 0) m_hold = m_pend_data;
      if (e_en && !e_we) begin
        m_pend = e_gnt;
        m_pend_data = shadow[oa[9:0]];
      end else begin
        m_pend = 3'b000;
      end
      if (e_we) shadow[oa[9:0]] = wdata[m_owner*32 +: 32];
      if (acc && !inr)  m_err = 1'b1;
      else if (clr)     m_err = 1'b0;

      if (m_owner < 0) begin
        for (int i = 1; i <= 3; i++) begin
          int c;
          c = (m_lastw + i) % 3;
          if (req[c] && (!lock || c == 2)) begin
            m_owner = c;
            m_beats = 0;
            break;
          end
        end
      end else begin
        fin = abort || !req[m_owner] || (acc && (last[m_owner] || m_beats == MAXB - 1));
        if (acc) m_beats++;
        if (fin) begin
          m_lastw = m_owner;
          m_owner = -1;
        end
      end
      m_lock_prev = lock;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
